// File: rtl/seq_pkg.sv
// Shared types and widths for the ALU micro-sequencer.
package seq_pkg;

    localparam int unsigned OP_W   = 2;
    localparam int unsigned OPND_W = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StGap,
        StDone
    } seq_state_t;

    typedef enum logic [OP_W-1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpXor = 2'b10,
        OpShl = 2'b11
    } alu_op_t;

    typedef struct packed {
        alu_op_t           op;
        logic [OPND_W-1:0] opnd;
    } seq_instr_t;

endpackage

// File: rtl/alu_seq_ctrl_rise_detect.sv
// Registered rising-edge detector for a level button: one event per press.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Records a short {op, operand} program from buttons and replays it to the accumulator ALU.
// Define SEQ_LOOP_EN to let the loop input restart playback from slot 0 after the last slot.
module alu_seq_ctrl #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned OP_W   = seq_pkg::OP_W,
    parameter int unsigned OPND_W = seq_pkg::OPND_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load_btn,
    input  logic [OP_W-1:0]            load_op,
    input  logic [OPND_W-1:0]          load_opnd,
    input  logic                       start_btn,
    input  logic                       clear_btn,
    input  logic                       loop,
    output logic                       alu_en,
    output logic [OP_W-1:0]            alu_op,
    output logic [OPND_W-1:0]          alu_opnd,
    output logic                       busy,
    output logic                       done,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    import seq_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic w_load_rise;
    logic w_start_rise;
    logic w_clear_rise;

    rise_detect u_load_rise (
        .clock   (clock),
        .reset   (reset),
        .i_level (load_btn),
        .o_rise  (w_load_rise)
    );

    rise_detect u_start_rise (
        .clock   (clock),
        .reset   (reset),
        .i_level (start_btn),
        .o_rise  (w_start_rise)
    );

    rise_detect u_clear_rise (
        .clock   (clock),
        .reset   (reset),
        .i_level (clear_btn),
        .o_rise  (w_clear_rise)
    );

    seq_state_t        r_state, w_state_d;
    logic [CNT_W-1:0]  r_count, w_count_d;
    logic [PTR_W-1:0]  r_rd_ptr, w_rd_ptr_d;
    logic              w_wr_en;
    logic              w_last_slot;
    seq_instr_t        w_wr_entry;
    seq_instr_t        w_issue_entry;
    seq_instr_t        r_buf [DEPTH];

    logic              r_alu_en;
    logic [OP_W-1:0]   r_alu_op;
    logic [OPND_W-1:0] r_alu_opnd;
    logic              r_busy;
    logic              r_done;
    logic              r_full;

    assign w_wr_entry  = '{op: alu_op_t'(load_op), opnd: load_opnd};
    assign w_last_slot = (CNT_W'(r_rd_ptr) == (r_count - CNT_W'(1)));

    // A write and the first issue can land on the same slot (load+start from empty).
    assign w_issue_entry = (w_wr_en && (r_count[PTR_W-1:0] == w_rd_ptr_d)) ? w_wr_entry
                                                                          : r_buf[w_rd_ptr_d];

`ifdef SEQ_LOOP_EN
`else
    logic w_unused_loop;
    assign w_unused_loop = loop;
`endif

    always_comb begin
        w_state_d  = r_state;
        w_count_d  = r_count;
        w_rd_ptr_d = r_rd_ptr;
        w_wr_en    = 1'b0;

        if (w_clear_rise) begin
            w_state_d  = StIdle;
            w_count_d  = '0;
            w_rd_ptr_d = '0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_load_rise && (r_count != FULL_CNT)) begin
                        w_wr_en   = 1'b1;
                        w_count_d = r_count + CNT_W'(1);
                    end
                    if (w_start_rise && (w_count_d != '0)) begin
                        w_state_d  = StIssue;
                        w_rd_ptr_d = '0;
                    end
                end
                StIssue: begin
                    w_state_d = StGap;
                end
                StGap: begin
                    if (w_last_slot) begin
`ifdef SEQ_LOOP_EN
                        if (loop) begin
                            w_state_d  = StIssue;
                            w_rd_ptr_d = '0;
                        end else begin
                            w_state_d = StDone;
                        end
`else
                        w_state_d = StDone;
`endif
                    end else begin
                        w_state_d  = StIssue;
                        w_rd_ptr_d = r_rd_ptr + PTR_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_alu_en   <= 1'b0;
            r_alu_op   <= '0;
            r_alu_opnd <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_count  <= w_count_d;
            r_rd_ptr <= w_rd_ptr_d;
            // Outputs decode the next state so they line up with it cycle for cycle.
            r_alu_en <= (w_state_d == StIssue);
            r_busy   <= (w_state_d == StIssue) || (w_state_d == StGap);
            r_done   <= (w_state_d == StDone);
            r_full   <= (w_count_d == FULL_CNT);
            if (w_state_d == StIssue) begin
                r_alu_op   <= OP_W'(w_issue_entry.op);
                r_alu_opnd <= OPND_W'(w_issue_entry.opnd);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_buf[r_count[PTR_W-1:0]] <= w_wr_entry;
        end
    end

    assign alu_en   = r_alu_en;
    assign alu_op   = r_alu_op;
    assign alu_opnd = r_alu_opnd;
    assign busy     = r_busy;
    assign done     = r_done;
    assign full     = r_full;
    assign count    = r_count;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl; the program is modelled as a queue and playback as a
// timeline (slot i pulses 1+2i cycles after the start edge).
module tb_alu_seq_ctrl;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned OPND_W = 3;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W  = OP_W + OPND_W;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              load_btn = 1'b0;
    logic [OP_W-1:0]   load_op = '0;
    logic [OPND_W-1:0] load_opnd = '0;
    logic              start_btn = 1'b0;
    logic              clear_btn = 1'b0;
    logic              loop = 1'b0;
    logic              alu_en;
    logic [OP_W-1:0]   alu_op;
    logic [OPND_W-1:0] alu_opnd;
    logic              busy;
    logic              done;
    logic              full;
    logic [CNT_W-1:0]  count;

    alu_seq_ctrl #(
        .DEPTH  (DEPTH),
        .OP_W   (OP_W),
        .OPND_W (OPND_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load_btn  (load_btn),
        .load_op   (load_op),
        .load_opnd (load_opnd),
        .start_btn (start_btn),
        .clear_btn (clear_btn),
        .loop      (loop),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .alu_opnd  (alu_opnd),
        .busy      (busy),
        .done      (done),
        .full      (full),
        .count     (count)
    );

    always #5 clock = ~clock;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [ENT_W-1:0] prog_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_entry(input logic [OP_W-1:0] op, input logic [OPND_W-1:0] opnd,
                              input int unsigned hold);
        load_op   = op;
        load_opnd = opnd;
        load_btn  = 1'b1;
        tick();
        if (prog_q.size() < DEPTH) prog_q.push_back({op, opnd});
        check_eq("load_count", 32'(count), 32'(prog_q.size()));
        check_eq("load_full", 32'(full), 32'(prog_q.size() == DEPTH));
        repeat (hold - 1) tick();
        load_btn = 1'b0;
        tick();
    endtask

    task automatic press_clear();
        clear_btn = 1'b1;
        tick();
        check_eq("clr_count", 32'(count), 0);
        check_eq("clr_state", {29'b0, alu_en, busy, done}, 0);
        clear_btn = 1'b0;
        prog_q.delete();
        tick();
    endtask

    task automatic run_playback(input bit hold_start);
        int k;
        int s;
        k = prog_q.size();
        start_btn = 1'b1;
        tick();
        if (!hold_start) start_btn = 1'b0;
        for (int c = 0; c <= 2 * k; c++) begin
            s = (c / 2 < k) ? c / 2 : k - 1;
            check_eq("pb_en", 32'(alu_en), 32'((c % 2 == 0) && (c < 2 * k)));
            check_eq("pb_busy", 32'(busy), 32'(c < 2 * k));
            check_eq("pb_done", 32'(done), 32'(c == 2 * k));
            check_eq("pb_slot", 32'({alu_op, alu_opnd}), 32'(prog_q[s]));
            if (c < 2 * k) tick();
        end
        if (hold_start) begin
            repeat (3) begin
                tick();
                check_eq("hold_en", 32'(alu_en), 0);
                check_eq("hold_done", 32'(done), 1);
            end
            start_btn = 1'b0;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        #1 reset = 1'b1;
        #1;
        check_eq("rst_outs", 32'({alu_en, alu_op, alu_opnd, busy, done, full, count}), 0);
        tick();
        reset = 1'b0;
        tick();

        // Basic program from the plan.
        load_entry(2'b00, 3'd3, 1);
        load_entry(2'b01, 3'd1, 2);
        load_entry(2'b11, 3'd2, 1);
        run_playback(1'b0);

        // Empty start does nothing.
        press_clear();
        start_btn = 1'b1;
        tick();
        check_eq("empty_en", 32'({alu_en, busy, done}), 0);
        start_btn = 1'b0;
        tick();
        check_eq("empty_busy", 32'({alu_en, busy}), 0);

        // Overflow: ninth load is dropped, playback emits eight pulses.
        for (int i = 0; i < 9; i++) load_entry(2'($urandom), 3'($urandom), 1);
        check_eq("ovf_count", 32'(count), DEPTH);
        run_playback(1'b0);

        // Load and start in the same cycle from empty.
        press_clear();
        load_op = 2'b10; load_opnd = 3'd5;
        load_btn = 1'b1; start_btn = 1'b1;
        tick();
        prog_q.push_back({2'b10, 3'd5});
        check_eq("ls_en", 32'(alu_en), 1);
        check_eq("ls_slot", 32'({alu_op, alu_opnd}), 32'(prog_q[0]));
        check_eq("ls_count", 32'(count), 1);
        load_btn = 1'b0; start_btn = 1'b0;
        tick();
        tick();
        check_eq("ls_done", 32'({done, busy}), 32'(2'b10));

        // Randomized programs, with optional held start and DONE-state append.
        for (int it = 0; it < 8; it++) begin
            press_clear();
            k = $urandom_range(1, DEPTH);
            for (int i = 0; i < k; i++) begin
                load_entry(2'($urandom), 3'($urandom), $urandom_range(1, 3));
                repeat ($urandom_range(0, 2)) tick();
            end
            run_playback(1'($urandom));
            if (prog_q.size() < DEPTH) load_entry(2'($urandom), 3'($urandom), 1);
            check_eq("app_done", 32'(done), 1);
            run_playback(1'b0);
        end

        // Clear wins over start during the GAP of slot 1.
        press_clear();
        for (int i = 0; i < 3; i++) load_entry(2'($urandom), 3'($urandom), 1);
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        tick();
        tick();
        check_eq("cp_slot1", 32'(alu_en), 1);
        tick();
        clear_btn = 1'b1; start_btn = 1'b1;
        tick();
        check_eq("cp_outs", 32'({alu_en, busy, done, full, count}), 0);
        clear_btn = 1'b0; start_btn = 1'b0;
        prog_q.delete();
        repeat (4) begin
            tick();
            check_eq("cp_quiet", 32'({alu_en, busy, done}), 0);
        end

`ifdef SEQ_LOOP_EN
        load_entry(2'b01, 3'd6, 1);
        load_entry(2'b10, 3'd2, 1);
        loop = 1'b1;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        for (int c = 0; c < 13; c++) begin
            if (c == 8) loop = 1'b0;
            check_eq("loop_en", 32'(alu_en), 32'((c % 2 == 0) && (c < 12)));
            check_eq("loop_done", 32'(done), 32'(c == 12));
            check_eq("loop_slot", 32'({alu_op, alu_opnd}), 32'(prog_q[(c / 2) % 2]));
            if (c < 12) tick();
        end
`endif

        // Asynchronous reset in the middle of an ISSUE cycle.
        press_clear();
        load_entry(2'b11, 3'd7, 1);
        load_entry(2'b00, 3'd1, 1);
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check_eq("mr_issue", 32'(alu_en), 1);
        #2 reset = 1'b1;
        #1;
        check_eq("mr_outs", 32'({alu_en, alu_op, alu_opnd, busy, done, full, count}), 0);
        prog_q.delete();
        tick();
        reset = 1'b0;
        tick();
        check_eq("mr_count", 32'(count), 0);
        start_btn = 1'b1;
        repeat (3) begin
            tick();
            check_eq("mr_idle", 32'({alu_en, busy, done}), 0);
        end
        start_btn = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

- Micro-sequencer feeding the 8-bit accumulator ALU: add, subtract, XOR, and left-shift of a 3-bit operand.
- Button presses store a short program of {op, operand} entries in an internal buffer. A start press replays the program into the ALU.
- Each instruction is issued as a one-cycle enable pulse followed by a mandatory low cycle, because the accumulator edge-detects its enable.
- The block sits between the board switches/buttons and the accumulator's en/op/operand inputs.

## Interface
Parameters:
- DEPTH, 8, program buffer entries (power of two, ≥2)
- OP_W, 2, ALU opcode width
- OPND_W, 3, operand width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- load_btn  in  1  level button; rising edge writes {load_op, load_opnd} at the write pointer
- load_op  in  OP_W  opcode to store
- load_opnd  in  OPND_W  operand to store
- start_btn  in  1  level button; rising edge begins playback
- clear_btn  in  1  level button; rising edge aborts playback and empties the buffer
- loop  in  1  repeat-program request; used only under SEQ_LOOP_EN
- alu_en  out  1  one-cycle issue pulse to the accumulator
- alu_op  out  OP_W  opcode for the current slot
- alu_opnd  out  OPND_W  operand for the current slot
- busy  out  1  high in ISSUE or GAP
- done  out  1  high in DONE
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH+1)  stored entries

## Operation
- Button edges: each button is registered once; a rising edge is "prev=0, now=1". Holding a button produces exactly one event.
- Opcode encoding: 00 ADD, 01 SUB, 10 XOR, 11 SHL.
- States: IDLE, ISSUE, GAP, DONE.
- IDLE:
  - A load edge with count<DEPTH writes the entry at index count; count increments.
  - A load edge when full is dropped; count and buffer are unchanged.
  - A start edge with count>0 moves to ISSUE with rd_ptr=0.
  - A start edge with count==0 is ignored.
  - Load and start edges in the same cycle: the write completes, then playback starts with the updated count.
- ISSUE: alu_en=1, alu_op/alu_opnd = buf[rd_ptr]. Next state is GAP.
- GAP:
  - alu_en=0; alu_op/alu_opnd hold their values.
  - If rd_ptr==count-1, move to DONE. Otherwise increment rd_ptr and move to ISSUE.
- DONE:
  - done=1; the buffer is retained.
  - A start edge replays from slot 0.
  - A load edge appends an entry, subject to the full rule; state stays DONE.
- Clear edge in any state:
  - Next state is IDLE; count=0, rd_ptr=0, alu_en=0.
  - Clear wins over a simultaneous start or load edge.
- Load and start edges are ignored in ISSUE and GAP.
- Pointer arithmetic is unsigned. rd_ptr never exceeds count-1. There is no wrap: the buffer is linear, not circular.

## Timing
- All outputs are registered.
- Reset values: alu_en=0, alu_op=0, alu_opnd=0, busy=0, done=0, full=0, count=0. State is IDLE, buffer contents are don't-care.
- Start edge sampled at clock edge N:
  - Slot i has alu_en high during cycle N+1+2i.
  - done rises at cycle N+1+2·count.
  - Playback latency is 2·count cycles.
- A load edge at clock edge N updates count/full at N+1.
- A clear edge at N: alu_en=0, busy=0, done=0, count=0 from N+1. A clear in mid-ISSUE truncates nothing already pulsed.
- Reset asserted mid-playback forces all reset values immediately; there is no pending pulse afterwards.

## Configuration
- Macro SEQ_LOOP_EN defined:
  - In GAP of the last slot, loop=1 moves to ISSUE with rd_ptr=0 instead of DONE.
  - loop is sampled at that GAP only.
  - Clear still aborts playback.
- Macro undefined: the loop port is ignored and the last slot always goes to DONE. No loop logic is synthesized.

## Structure
- Package seq_pkg:
  - state enum seq_state_t
  - opcode enum alu_op_t (ADD/SUB/XOR/SHL)
  - packed struct seq_instr_t {op, opnd}
  - localparams OP_W and OPND_W
- Sub-module rise_detect: a registered rising-edge detector, instantiated three times (load, start, clear).
- Top level: buffer array of seq_instr_t, pointers, FSM, output registers.

## Test plan
- Reset: assert reset mid-ISSUE → all outputs 0 in the same cycle; after release, count=0 and state is IDLE.
- Basic playback: load (00,3), (01,1), (11,2), then start edge at N → alu_en high at N+1, N+3, N+5 carrying (00,3), (01,1), (11,2); done=1 at N+7; busy low at N+7.
- Overflow (DEPTH=8): 9 load edges → full=1 after the 8th, count stays 8, 9th dropped; start → exactly 8 alu_en pulses.
- Empty start and button hold: start edge with count=0 → no alu_en, state IDLE. start_btn held high through DONE → no replay until released and pressed again.
- Clear priority: clear and start edges together during GAP of slot 1 → next cycle IDLE, count=0, alu_en=0, done=0; no further pulses.
- Loop (SEQ_LOOP_EN): 2-entry program with loop=1 → slots issue 0,1,0,1,… with a gap cycle between each; drop loop during slot 0 → done after the next slot 1 GAP.
